// File: rtl/mp3_ram_fetch_arbiter.sv
// Arbitrates the single-port sample RAM between host bus accesses and MP3
// playback prefetch, which fills a small word FIFO feeding the descrambler.
module mp3_ram_fetch_arbiter #(
    parameter int ADDR_WIDTH = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int LOW_WATER  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  hostReq,
    input  logic                  hostWrite,
    input  logic [ADDR_WIDTH-1:0] hostAddr,
    input  logic [15:0]           hostWData,
    output logic [15:0]           hostRData,
    output logic                  hostAck,
    output logic                  ramReq,
    output logic                  ramWrite,
    output logic [ADDR_WIDTH-1:0] ramAddr,
    output logic [15:0]           ramWData,
    input  logic [15:0]           ramRData,
    input  logic                  ramAck,
    output logic                  feederReady,
    input  logic                  feederAddrWrite,
    input  logic [ADDR_WIDTH-1:0] feederAddrWData,
    output logic [ADDR_WIDTH-1:0] feederAddr,
    output logic [15:0]           wordOut,
    output logic                  wordReady,
    input  logic                  wordAck
);

    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] LOW_COUNT  = CNT_WIDTH'(LOW_WATER);

    typedef enum logic [1:0] {
        IDLE,
        HOST,
        MP3
    } state_t;

    state_t state, next_state;

    logic [15:0]          fifo_mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0] head, tail;
    logic [CNT_WIDTH-1:0] count;

    logic seek, push, pop, mp3_want, host_want, grant_host, grant_mp3;

    assign feederReady = (state != MP3);
    assign seek        = feederAddrWrite & feederReady;
    assign push        = (state == MP3) & ramAck;
    assign pop         = wordAck & (count != '0);
    assign mp3_want    = enable & (count != FULL_COUNT) & ~feederAddrWrite;
    // hostReq is still high during the hostAck cycle; that must not re-grant
    assign host_want   = hostReq & ~hostAck;

    assign wordReady = (count != '0);
    assign wordOut   = wordReady ? fifo_mem[head] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        grant_host = 1'b0;
        grant_mp3  = 1'b0;
        case (state)
            IDLE: begin
                if (host_want && (!mp3_want || count > LOW_COUNT)) begin
                    grant_host = 1'b1;
                    next_state = HOST;
                end else if (mp3_want) begin
                    grant_mp3  = 1'b1;
                    next_state = MP3;
                end
            end
            HOST: if (ramAck) next_state = IDLE;
            MP3:  if (ramAck) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ramReq   <= 1'b0;
            ramWrite <= 1'b0;
            ramAddr  <= '0;
            ramWData <= '0;
        end else if (grant_host) begin
            ramReq   <= 1'b1;
            ramWrite <= hostWrite;
            ramAddr  <= hostAddr;
            ramWData <= hostWData;
        end else if (grant_mp3) begin
            ramReq   <= 1'b1;
            ramWrite <= 1'b0;
            ramAddr  <= feederAddr;
        end else if (state != IDLE && ramAck) begin
            ramReq   <= 1'b0;
            ramWrite <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hostAck   <= 1'b0;
            hostRData <= '0;
        end else begin
            hostAck <= (state == HOST) && ramAck;
            if (state == HOST && ramAck && !ramWrite) hostRData <= ramRData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     feederAddr <= '0;
        else if (seek) feederAddr <= feederAddrWData;
        else if (push) feederAddr <= feederAddr + 1'b1;
    end

    // A seek flushes the FIFO and wins over any pop in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (seek) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[tail] <= ramRData;
    end

endmodule

// File: tb/tb_mp3_ram_fetch_arbiter.sv
// Self-checking bench for mp3_ram_fetch_arbiter: a RAM responder plus a
// transaction-level model (word queue, playback address, host memory image).
module tb_mp3_ram_fetch_arbiter;

    localparam int AW    = 24;
    localparam int DEPTH = 4;
    localparam int LOW   = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          hostReq = 1'b0;
    logic          hostWrite = 1'b0;
    logic [AW-1:0] hostAddr = '0;
    logic [15:0]   hostWData = '0;
    logic [15:0]   hostRData;
    logic          hostAck;
    logic          ramReq;
    logic          ramWrite;
    logic [AW-1:0] ramAddr;
    logic [15:0]   ramWData;
    logic [15:0]   ramRData = '0;
    logic          ramAck = 1'b0;
    logic          feederReady;
    logic          feederAddrWrite = 1'b0;
    logic [AW-1:0] feederAddrWData = '0;
    logic [AW-1:0] feederAddr;
    logic [15:0]   wordOut;
    logic          wordReady;
    logic          wordAck = 1'b0;

    mp3_ram_fetch_arbiter dut (
        .clk(clk), .reset(reset), .enable(enable),
        .hostReq(hostReq), .hostWrite(hostWrite), .hostAddr(hostAddr),
        .hostWData(hostWData), .hostRData(hostRData), .hostAck(hostAck),
        .ramReq(ramReq), .ramWrite(ramWrite), .ramAddr(ramAddr),
        .ramWData(ramWData), .ramRData(ramRData), .ramAck(ramAck),
        .feederReady(feederReady), .feederAddrWrite(feederAddrWrite),
        .feederAddrWData(feederAddrWData), .feederAddr(feederAddr),
        .wordOut(wordOut), .wordReady(wordReady), .wordAck(wordAck)
    );

    always #5 clk = ~clk;

    logic [15:0]   wordQ[$];
    logic [15:0]   ramImage[logic [AW-1:0]];
    logic [AW-1:0] expAddr;
    logic [15:0]   lastRData;
    bit            inTxn, txnIsHost, txnWrite;
    logic [AW-1:0] txnAddr;
    logic [15:0]   txnData;
    int            lat;
    bit            idleAtDrive, hostEligAtDrive, mp3WantAtDrive, readyAtDrive;
    int            countAtDrive;
    int            hostPhase, hostWait, hostAckCount;
    int            popRate, hostRate, seekRate, maxLat, forcePops;
    bit            popOnAck, randEnable, enTarget, seekPending, hostGo, hostGoWrite;
    logic [AW-1:0] seekTarget, hostGoAddr;
    logic [15:0]   hostGoData;
    logic [AW-1:0] mp3Log[$];
    int            typeLog[$];
    int            checkCount = 0;
    int            failCount = 0;

    function automatic logic [15:0] memVal(input logic [AW-1:0] a);
        if (ramImage.exists(a)) return ramImage[a];
        return a[15:0] ^ {a[23:16], a[23:16]} ^ 16'h5A3C;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        wordQ.delete();
        expAddr = '0; lastRData = '0; inTxn = 0; txnIsHost = 0; txnWrite = 0; lat = 0;
        idleAtDrive = 1; hostEligAtDrive = 0; mp3WantAtDrive = 0; readyAtDrive = 1;
        countAtDrive = 0; hostPhase = 0; hostWait = 0; seekPending = 0; forcePops = 0;
        ramAck = 0; wordAck = 0; feederAddrWrite = 0; hostReq = 0; enable = 0; enTarget = 0;
    endtask

    // One clock of stimulus: retire last cycle's effects in the model, check
    // outputs, then drive the next set of inputs at the falling edge.
    task automatic applyStimulus();
        bit hostAckExp, expectNew, winHost;
        @(negedge clk);
        if (feederAddrWrite && readyAtDrive) begin
            wordQ.delete();
            expAddr = feederAddrWData;
            mp3Log.delete();
        end else if (wordAck && wordQ.size() > 0) begin
            void'(wordQ.pop_front());
        end
        hostAckExp = 0;
        if (ramAck) begin
            if (txnIsHost) begin
                hostAckExp = 1;
                hostAckCount++;
                if (txnWrite) ramImage[txnAddr] = txnData;
                else          lastRData = memVal(txnAddr);
            end else begin
                wordQ.push_back(memVal(txnAddr));
                expAddr = expAddr + 1'b1;
            end
            inTxn = 0;
        end
        checkOutput("hostAck", hostAck, hostAckExp);
        checkOutput("hostRData", hostRData, lastRData);
        checkOutput("wordReady", wordReady, wordQ.size() != 0);
        if (wordQ.size() != 0) checkOutput("wordOut", wordOut, wordQ[0]);
        checkOutput("feederAddr", feederAddr, expAddr);
        if (!inTxn) begin
            expectNew = idleAtDrive && (hostEligAtDrive || mp3WantAtDrive);
            checkOutput("ramReqIssue", ramReq, expectNew);
            if (ramReq && expectNew) begin
                winHost   = hostEligAtDrive && !(mp3WantAtDrive && countAtDrive <= LOW);
                inTxn     = 1;
                txnIsHost = winHost;
                txnWrite  = winHost ? hostWrite : 1'b0;
                txnAddr   = winHost ? hostAddr : expAddr;
                txnData   = hostWData;
                lat       = $urandom_range(maxLat, 0);
                typeLog.push_back(int'(winHost));
                if (!winHost) mp3Log.push_back(expAddr);
            end
        end
        if (inTxn) begin
            checkOutput("ramReqHold", ramReq, 1);
            checkOutput("ramAddr", ramAddr, txnAddr);
            checkOutput("ramWrite", ramWrite, txnWrite);
            if (txnWrite) checkOutput("ramWData", ramWData, txnData);
        end
        checkOutput("feederReady", feederReady, !(inTxn && !txnIsHost));

        ramAck = 0; wordAck = 0; feederAddrWrite = 0;
        if (inTxn) begin
            if (lat == 0) begin
                ramAck   = 1;
                ramRData = txnWrite ? 16'($urandom) : memVal(txnAddr);
            end else begin
                lat--;
            end
        end
        readyAtDrive = !(inTxn && !txnIsHost);
        case (hostPhase)
            1: begin
                if (hostAckExp) hostPhase = 2;
                else begin
                    hostWait++;
                    if (hostWait > 300) begin
                        checkOutput("hostWait", hostWait, 0);
                        hostReq = 0;
                        hostPhase = 3;
                    end
                end
            end
            2: begin hostReq = 0; hostPhase = 3; end
            3: hostPhase = 0;
            default: begin
                if (hostGo || $urandom_range(99, 0) < hostRate) begin
                    hostReq   = 1;
                    hostWrite = hostGo ? hostGoWrite : 1'($urandom_range(1, 0));
                    hostAddr  = hostGo ? hostGoAddr : AW'($urandom);
                    hostWData = hostGo ? hostGoData : 16'($urandom);
                    hostGo    = 0;
                    hostPhase = 1;
                    hostWait  = 0;
                end
            end
        endcase
        if (forcePops > 0 && wordQ.size() > 0) begin
            wordAck = 1;
            forcePops--;
        end else if (popOnAck) begin
            wordAck = ramAck && !txnIsHost && wordQ.size() >= 2;
        end else if ($urandom_range(99, 0) < (wordQ.size() > 0 ? popRate : popRate / 4)) begin
            wordAck = 1;
        end
        if (seekPending) begin
            if (readyAtDrive) begin
                feederAddrWrite = 1;
                feederAddrWData = seekTarget;
                seekPending = 0;
            end
        end else if ($urandom_range(999, 0) < seekRate) begin
            feederAddrWrite = 1;
            feederAddrWData = AW'($urandom);
        end
        if (randEnable && $urandom_range(99, 0) < 5) enTarget = !enTarget;
        enable = enTarget;
        idleAtDrive     = !inTxn;
        hostEligAtDrive = hostReq && !hostAckExp;
        mp3WantAtDrive  = enable && wordQ.size() < DEPTH && !feederAddrWrite;
        countAtDrive    = wordQ.size();
    endtask

    initial begin
        int drained;
        popRate = 0; hostRate = 0; seekRate = 0; maxLat = 2; popOnAck = 0;
        randEnable = 0; hostGo = 0; hostAckCount = 0;
        resetModel();
        reset = 1;
        repeat (3) @(negedge clk);
        checkOutput("rstRamReq", ramReq, 0);
        checkOutput("rstRamWrite", ramWrite, 0);
        checkOutput("rstRamAddr", ramAddr, 0);
        checkOutput("rstRamWData", ramWData, 0);
        checkOutput("rstHostAck", hostAck, 0);
        checkOutput("rstHostRData", hostRData, 0);
        checkOutput("rstFeederAddr", feederAddr, 0);
        checkOutput("rstWordReady", wordReady, 0);
        checkOutput("rstWordOut", wordOut, 0);
        checkOutput("rstFeederReady", feederReady, 1);
        reset = 0;

        // seek to 0x100 and fill the FIFO without draining it
        enTarget = 1; seekPending = 1; seekTarget = 24'h000100;
        repeat (30) applyStimulus();
        checkOutput("fillFeederAddr", feederAddr, 24'h000104);
        checkOutput("fillFetchCount", mp3Log.size(), 4);
        for (int i = 0; i < 4 && i < mp3Log.size(); i++)
            checkOutput("fillFetchAddr", mp3Log[i], 24'h000100 + i);
        checkOutput("fillWordReady", wordReady, 1);

        // full FIFO: host read is served straight away
        typeLog.delete(); hostAckCount = 0;
        hostGo = 1; hostGoWrite = 0; hostGoAddr = 24'h002000; hostGoData = '0;
        repeat (20) applyStimulus();
        checkOutput("fullHostAcks", hostAckCount, 1);
        checkOutput("fullHostRData", hostRData, memVal(24'h002000));
        checkOutput("fullTxnCount", typeLog.size(), 1);

        // one word left: MP3 wins the tie, host is next
        enTarget = 0; forcePops = 3;
        repeat (6) applyStimulus();
        typeLog.delete();
        enTarget = 1;
        hostGo = 1; hostGoWrite = 1; hostGoAddr = 24'h002001; hostGoData = 16'hBEEF;
        repeat (30) applyStimulus();
        checkOutput("lowTxnCount", typeLog.size() >= 2, 1);
        if (typeLog.size() >= 2) begin
            checkOutput("lowFirstIsMp3", typeLog[0], 0);
            checkOutput("lowSecondIsHost", typeLog[1], 1);
        end

        // address wrap at the top of the RAM
        popRate = 50; seekPending = 1; seekTarget = 24'hFFFFFE;
        repeat (40) applyStimulus();
        checkOutput("wrapFetchCount", mp3Log.size() >= 3, 1);
        if (mp3Log.size() >= 3) begin
            checkOutput("wrapFetch0", mp3Log[0], 24'hFFFFFE);
            checkOutput("wrapFetch1", mp3Log[1], 24'hFFFFFF);
            checkOutput("wrapFetch2", mp3Log[2], 24'h000000);
        end

        // pop coincident with push holds the level at two words
        popRate = 0; popOnAck = 1; seekPending = 1; seekTarget = 24'h000300;
        repeat (40) applyStimulus();
        enTarget = 0;
        repeat (6) applyStimulus();
        popOnAck = 0; popRate = 100; drained = 0;
        repeat (8) begin
            applyStimulus();
            if (wordReady) drained++;
        end
        checkOutput("pushPopLevel", drained, 2);
        popRate = 0;

        // reset in the middle of a fetch, then a stray late ramAck
        enTarget = 1; maxLat = 8; seekPending = 1; seekTarget = 24'h000500;
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            if (inTxn && !txnIsHost && lat > 1) break;
        end
        checkOutput("midFetchActive", ramReq, 1);
        #2 reset = 1;
        resetModel();
        repeat (2) @(negedge clk);
        reset = 0;
        ramAck = 1;
        @(negedge clk);
        ramAck = 0;
        checkOutput("lateAckRamReq", ramReq, 0);
        checkOutput("lateAckWordReady", wordReady, 0);
        checkOutput("lateAckFeederReady", feederReady, 1);
        checkOutput("lateAckHostAck", hostAck, 0);
        @(negedge clk);
        checkOutput("lateAckStillIdle", ramReq, 0);
        checkOutput("lateAckFeederAddr", feederAddr, 0);

        // randomized traffic from every requester
        maxLat = 3; hostRate = 15; popRate = 40; seekRate = 20;
        randEnable = 1; enTarget = 1;
        repeat (3000) applyStimulus();

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
